// File: rtl/tk1_sched.sv
// TK1 tweakey schedule for SKINNY: emits eight round TK1 subkeys per batch
// and advances the stored TK1 by P^8 on every accepted batch.
module tk1_sched #(
    parameter int ROUNDS = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [127:0] tk1_i,
    output logic [511:0] rtk_o,
    output logic         rtk_valid_o,
    input  logic         rtk_ready_i,
    output logic [3:0]   batch_o,
    output logic         last_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] tk1_o
);

    localparam int         NBATCH     = ROUNDS / 8;
    localparam logic [3:0] LAST_BATCH = 4'(NBATCH - 1);
    // PT packed as nibbles, entry 0 in the top nibble
    localparam logic [63:0] PT = 64'h9F8DAECB01234567;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e       st_q, st_d;
    logic [127:0] tk1_q, tk1_d;
    logic [3:0]   batch_q, batch_d;
    logic         done_q, done_d;
    logic         handshake;

    function automatic logic [127:0] perm(input logic [127:0] s);
        logic [127:0] r;
        int           src;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            src = int'(PT[63-4*i -: 4]);
            r[127-8*i -: 8] = s[127-8*src -: 8];
        end
        return r;
    endfunction

    // Purely combinational P^0..P^8 chain; stage 8 is the next batch's state
    logic [127:0] pchain [0:8];
    assign pchain[0] = tk1_q;

    for (genvar g = 0; g < 8; g++) begin : g_pt
        assign pchain[g+1]         = perm(pchain[g]);
        assign rtk_o[511-64*g -: 64] = pchain[g][127:64];
    end

    assign handshake   = (st_q == RUN) && rtk_ready_i;
    assign rtk_valid_o = (st_q == RUN);
    assign busy_o      = (st_q == RUN);
    assign last_o      = (st_q == RUN) && (batch_q == LAST_BATCH);
    assign batch_o     = batch_q;
    assign done_o      = done_q;
    assign tk1_o       = tk1_q;

    always_comb begin
        st_d    = st_q;
        tk1_d   = tk1_q;
        batch_d = batch_q;
        done_d  = 1'b0;
        case (st_q)
            IDLE: begin
                if (load_i) begin
                    tk1_d   = tk1_i;
                    batch_d = '0;
                    st_d    = RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    tk1_d = pchain[8];
                    if (batch_q == LAST_BATCH) begin
                        st_d   = IDLE;
                        done_d = 1'b1;
                    end else begin
                        batch_d = batch_q + 4'd1;
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            tk1_q   <= '0;
            batch_q <= '0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            tk1_q   <= tk1_d;
            batch_q <= batch_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_tk1_sched.sv
// Self-checking bench for tk1_sched: ROUNDS=40 instance against a cell-array
// reference model, plus a ROUNDS=16 instance for the short-schedule case.
module tb_tk1_sched;

    localparam int PT_TB [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
    localparam logic [127:0] IDENT = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk;
    logic         rst, load_i, rtk_ready_i;
    logic [127:0] tk1_i;
    logic [511:0] rtk_o;
    logic         rtk_valid_o, last_o, busy_o, done_o;
    logic [3:0]   batch_o;
    logic [127:0] tk1_o;

    logic         rst16, load16, ready16;
    logic [127:0] tk1_16, tk1o_16;
    logic [511:0] rtk16;
    logic         valid16, last16, busy16, done16;
    logic [3:0]   batch16;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state (ROUNDS=40 instance)
    logic [127:0] m_state;
    int           m_batch;
    bit           m_run, m_done;

    tk1_sched #(.ROUNDS(40)) dut (
        .clk(clk), .rst(rst), .load_i(load_i), .tk1_i(tk1_i),
        .rtk_o(rtk_o), .rtk_valid_o(rtk_valid_o), .rtk_ready_i(rtk_ready_i),
        .batch_o(batch_o), .last_o(last_o), .busy_o(busy_o),
        .done_o(done_o), .tk1_o(tk1_o)
    );

    tk1_sched #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst(rst16), .load_i(load16), .tk1_i(tk1_16),
        .rtk_o(rtk16), .rtk_valid_o(valid16), .rtk_ready_i(ready16),
        .batch_o(batch16), .last_o(last16), .busy_o(busy16),
        .done_o(done16), .tk1_o(tk1o_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] m_pow(input logic [127:0] s, input int k);
        logic [7:0]   c [16];
        logic [7:0]   n [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) c[i] = s[127-8*i -: 8];
        for (int j = 0; j < k; j++) begin
            for (int i = 0; i < 16; i++) n[i] = c[PT_TB[i]];
            c = n;
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = c[i];
        return r;
    endfunction

    function automatic logic [511:0] m_rtk(input logic [127:0] s);
        logic [511:0] r;
        logic [127:0] t;
        for (int k = 0; k < 8; k++) begin
            t = m_pow(s, k);
            r[511-64*k -: 64] = t[127:64];
        end
        return r;
    endfunction

    task automatic model_step(input logic r, input logic l, input logic rd);
        if (r) begin
            m_state = '0; m_batch = 0; m_run = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (l) begin
                    m_state = tk1_i; m_batch = 0; m_run = 1;
                end
            end else if (rd) begin
                m_state = m_pow(m_state, 8);
                if (m_batch == 4) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_batch++;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic rd);
        rst = r; load_i = l; rtk_ready_i = rd;
        model_step(r, l, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst16 = 1'b1; load16 = 1'b1; ready16 = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        rst16 = 1'b0; load16 = 1'b0; ready16 = 1'b0;
        n_checks++;
        if ({rtk_valid_o, busy_o, last_o, done_o, batch_o} !== 8'h00)
            $display("[TB] FAIL reset_ctrl: got %h want 00", {rtk_valid_o, busy_o, last_o, done_o, batch_o});
        else n_pass++;
        n_checks++;
        if (tk1_o !== 128'h0 || rtk_o !== 512'h0)
            $display("[TB] FAIL reset_data: got tk1 %h want 0", tk1_o);
        else n_pass++;
        n_checks++;
        if (valid16 !== 1'b0 || tk1o_16 !== 128'h0)
            $display("[TB] FAIL reset_dut16: got valid %b tk1 %h want 0", valid16, tk1o_16);
        else n_pass++;
    endtask

    task automatic test_vectors;
        tk1_i = IDENT;
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (rtk_valid_o !== 1'b1 || batch_o !== 4'd0 || busy_o !== 1'b1)
            $display("[TB] FAIL first_valid: got v%b b%0d busy%b want v1 b0 busy1", rtk_valid_o, batch_o, busy_o);
        else n_pass++;
        n_checks++;
        if (rtk_o[511:384] !== 128'h0001020304050607_090f080d0a0e0c0b)
            $display("[TB] FAIL kat_k01: got %h want 0001020304050607090f080d0a0e0c0b", rtk_o[511:384]);
        else n_pass++;
        n_checks++;
        if (rtk_o[383:320] !== 64'h0107000502060403)
            $display("[TB] FAIL kat_k2: got %h want 0107000502060403", rtk_o[383:320]);
        else n_pass++;
        n_checks++;
        if (rtk_o !== m_rtk(m_state))
            $display("[TB] FAIL batch0_model: got %h want %h", rtk_o, m_rtk(m_state));
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (tk1_o !== 128'h05060302070001040d0e0b0a0f08090c || batch_o !== 4'd1)
            $display("[TB] FAIL kat_batch1: got %h b%0d want 05060302070001040d0e0b0a0f08090c b1", tk1_o, batch_o);
        else n_pass++;
        while (m_run) drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (done_o !== 1'b1 || rtk_valid_o !== 1'b0 || tk1_o !== m_pow(IDENT, 40))
            $display("[TB] FAIL kat_final: got done%b v%b tk1 %h want done1 v0 %h", done_o, rtk_valid_o, tk1_o, m_pow(IDENT, 40));
        else n_pass++;
        // ready in IDLE must not change anything
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (done_o !== 1'b0 || tk1_o !== m_state || rtk_o !== m_rtk(m_state) || last_o !== 1'b0)
            $display("[TB] FAIL idle_ready: got done%b tk1 %h want done0 %h", done_o, tk1_o, m_state);
        else n_pass++;
    endtask

    task automatic test_random_stall;
        int           hs;
        int           cyc;
        bit           rd, ld;
        logic [511:0] p_rtk;
        logic [3:0]   p_batch;
        logic         p_last, p_valid;
        hs = 0;
        tk1_i = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b0, 1'b1, 1'b0);
        cyc = 0;
        while (m_run && cyc < 400) begin
            rd = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
            p_rtk = rtk_o; p_batch = batch_o; p_last = last_o; p_valid = rtk_valid_o;
            if (p_valid === 1'b1 && rd) hs++;
            tk1_i = {$urandom, $urandom, $urandom, $urandom};
            drive(1'b0, ld, rd);
            cyc++;
            if (p_valid === 1'b1 && !rd) begin
                n_checks++;
                if (rtk_o !== p_rtk || batch_o !== p_batch || last_o !== p_last)
                    $display("[TB] FAIL stall_stable: got b%0d last%b want b%0d last%b", batch_o, last_o, p_batch, p_last);
                else n_pass++;
            end
            n_checks++;
            if (rtk_o !== m_rtk(m_state) || tk1_o !== m_state || batch_o !== 4'(m_batch) ||
                rtk_valid_o !== m_run || last_o !== (m_run && m_batch == 4) || done_o !== m_done)
                $display("[TB] FAIL rand_model: got tk1 %h b%0d v%b d%b want %h b%0d v%b d%b",
                         tk1_o, batch_o, rtk_valid_o, done_o, m_state, m_batch, m_run, m_done);
            else n_pass++;
        end
        n_checks++;
        if (m_run || hs != 5)
            $display("[TB] FAIL rand_handshakes: got %0d (timeout %0d) want 5", hs, m_run);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        tk1_i = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (batch_o !== 4'd2 || rtk_valid_o !== 1'b1)
            $display("[TB] FAIL mid_batch2: got b%0d v%b want b2 v1", batch_o, rtk_valid_o);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({rtk_valid_o, busy_o, last_o, done_o, batch_o} !== 8'h00 || tk1_o !== 128'h0 || rtk_o !== 512'h0)
            $display("[TB] FAIL mid_reset: got v%b busy%b b%0d tk1 %h want all 0", rtk_valid_o, busy_o, batch_o, tk1_o);
        else n_pass++;
        tk1_i = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (batch_o !== 4'd0 || rtk_valid_o !== 1'b1 || tk1_o !== tk1_i || rtk_o !== m_rtk(m_state))
            $display("[TB] FAIL mid_restart: got b%0d v%b tk1 %h want b0 v1 %h", batch_o, rtk_valid_o, tk1_o, tk1_i);
        else n_pass++;
        while (m_run) drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 1'b0, 1'b0);
        tk1_i = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (last_o !== 1'b1 || batch_o !== 4'd4)
            $display("[TB] FAIL b2b_last: got last%b b%0d want last1 b4", last_o, batch_o);
        else n_pass++;
        // load during the final handshake is ignored
        drive(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (done_o !== 1'b1 || rtk_valid_o !== 1'b0 || tk1_o !== m_state)
            $display("[TB] FAIL b2b_done: got d%b v%b tk1 %h want d1 v0 %h", done_o, rtk_valid_o, tk1_o, m_state);
        else n_pass++;
        tk1_i = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (rtk_valid_o !== 1'b1 || done_o !== 1'b0 || batch_o !== 4'd0 || tk1_o !== tk1_i)
            $display("[TB] FAIL b2b_restart: got v%b d%b b%0d tk1 %h want v1 d0 b0 %h", rtk_valid_o, done_o, batch_o, tk1_o, tk1_i);
        else n_pass++;
    endtask

    task automatic test_rounds16;
        tk1_16 = IDENT; load16 = 1'b1; ready16 = 1'b0;
        @(posedge clk); #1;
        load16 = 1'b0; ready16 = 1'b1;
        n_checks++;
        if (valid16 !== 1'b1 || batch16 !== 4'd0 || last16 !== 1'b0)
            $display("[TB] FAIL r16_b0: got v%b b%0d last%b want v1 b0 last0", valid16, batch16, last16);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (valid16 !== 1'b1 || batch16 !== 4'd1 || last16 !== 1'b1 || tk1o_16 !== m_pow(IDENT, 8))
            $display("[TB] FAIL r16_b1: got v%b b%0d last%b want v1 b1 last1", valid16, batch16, last16);
        else n_pass++;
        @(posedge clk); #1;
        ready16 = 1'b0;
        n_checks++;
        if (done16 !== 1'b1 || valid16 !== 1'b0 || busy16 !== 1'b0 || tk1o_16 !== IDENT)
            $display("[TB] FAIL r16_done: got d%b v%b tk1 %h want d1 v0 %h", done16, valid16, tk1o_16, IDENT);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (done16 !== 1'b0 || valid16 !== 1'b0 || rtk16 !== m_rtk(IDENT))
            $display("[TB] FAIL r16_idle: got d%b v%b want d0 v0 rtk from state", done16, valid16);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; load_i = 1'b0; rtk_ready_i = 1'b0; tk1_i = '0;
        rst16 = 1'b1; load16 = 1'b0; ready16 = 1'b0; tk1_16 = '0;
        m_state = '0; m_batch = 0; m_run = 0; m_done = 0;
        test_reset;
        test_vectors;
        test_random_stall;
        test_reset_mid;
        test_back_to_back;
        test_rounds16;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tk1_sched.md
TK1_SCHED -- requirements
Module: tk1_sched

Interface
REQ-001 SHALL have parameter ROUNDS, default 40, the total SKINNY rounds per block; it SHALL be a multiple of 8 in the range 8..120.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port load_i, input, 1 bit, a request to start a new schedule from tk1_i.
REQ-005 SHALL have port tk1_i, input, 128 bits, the initial TK1 (counter/domain); cell 0 = tk1_i[127:120], cell 15 = tk1_i[7:0].
REQ-006 SHALL have port rtk_o, output, 512 bits, the eight round TK1 subkeys of the current batch.
REQ-007 SHALL have port rtk_valid_o, output, 1 bit; when high, rtk_o holds a valid batch.
REQ-008 SHALL have port rtk_ready_i, input, 1 bit, the consumer's acceptance of the current batch.
REQ-009 SHALL have port batch_o, output, 4 bits, the index of the current batch, 0..ROUNDS/8-1.
REQ-010 SHALL have port last_o, output, 1 bit; it is high with rtk_valid_o when batch_o = ROUNDS/8-1.
REQ-011 SHALL have port busy_o, output, 1 bit; it is high while the FSM is in RUN.
REQ-012 SHALL have port done_o, output, 1 bit, a one-cycle pulse after the final batch is accepted.
REQ-013 SHALL have port tk1_o, output, 128 bits, the current internal TK1 state register.

Function
REQ-014 SHALL define P as the SKINNY cell permutation: new cell i = old cell PT[i], with PT = 9,15,8,13,10,14,12,11,0,1,2,3,4,5,6,7.
REQ-015 SHALL build the 8-round advance, P^8, from eight chained P stages (the existing pt8 datapath), with no extra register inside the chain.
REQ-016 SHALL implement a two-state FSM: IDLE and RUN.
REQ-017 IDLE: load_i=1 SHALL set state <= tk1_i, batch <= 0, and move to RUN on the next edge.
REQ-018 RUN: rtk_valid_o SHALL be 1; rtk_o, batch_o and last_o SHALL stay stable until the handshake (rtk_valid_o & rtk_ready_i).
REQ-019 In RUN, rtk_o SHALL carry P^k(state) cells 0..7 (64 bits) for k = 0..7, with k=0 in rtk_o[511:448] and k=7 in rtk_o[63:0].
REQ-020 A handshake SHALL apply state <= P^8(state) on every batch, including the last.
REQ-021 A handshake that is not the last SHALL also apply batch <= batch+1 and keep the FSM in RUN.
REQ-022 The last-batch handshake SHALL return the FSM to IDLE, assert done_o on the next cycle only, and leave tk1_o = P^ROUNDS(tk1_i) in IDLE.
REQ-023 Output latency: the first batch SHALL be valid exactly one cycle after load_i is sampled in IDLE; each following batch SHALL be valid the cycle after the prior handshake.
REQ-024 load_i SHALL be ignored while in RUN, including in the cycle of the last handshake.
REQ-025 rtk_ready_i SHALL be ignored in IDLE.
REQ-026 rtk_ready_i held at 0 SHALL stall indefinitely with no state change.
REQ-027 In IDLE, rtk_valid_o, last_o and busy_o SHALL be 0, and rtk_o SHALL still be derived from state.

Reset
REQ-028 rst=1 SHALL force, on the next edge: FSM=IDLE, state=0, batch=0, done_o=0; hence rtk_valid_o=0, busy_o=0, last_o=0, tk1_o=0, rtk_o=0.
REQ-029 rst SHALL override load_i and any handshake in the same cycle, including mid-RUN, and SHALL discard any pending batch.

Verification
REQ-030 ROUNDS=40, tk1_i=000102..0f, load pulse, ready=1 -> valid the next cycle with rtk_o[511:384] = 0001020304050607_090f080d0a0e0c0b; batch 1 tk1_o = 05060302070001040d0e0b0a0f08090c.
REQ-031 Same stimulus, round k=2 slice (rtk_o[383:320] of batch 0) -> 0107000502060403.
REQ-032 ROUNDS=16, identity load -> exactly 2 batches, last_o on batch 1, done_o one cycle later, tk1_o = 000102..0f.
REQ-033 ROUNDS=40, ready toggled randomly -> exactly 5 handshakes, outputs stable during stalls, and load_i pulses during RUN have no effect.
REQ-034 Assert rst during batch 2 with ready=0 -> the next cycle shows all outputs 0 and IDLE; a new load then restarts at batch 0.
REQ-035 Load issued the cycle after done_o -> the new schedule starts normally, and rtk_valid_o is observed low for exactly the cycle of done_o.
